// File: rtl/train_feeder.sv
// Training-set sequencer for the neuron: holds host-loaded samples and replays them
// epoch after epoch until the neuron reports learned or the epoch limit is reached.
module train_feeder #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int MAX_EPOCHS = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [6:0]    load_x1,
    input  logic [6:0]    load_x2,
    input  logic [1:0]    load_t,
    input  logic [AW:0]   num_samples,
    input  logic          go,
    input  logic          learned,
    input  logic          updating,
    output logic          start,
    output logic [6:0]    x1,
    output logic [6:0]    x2,
    output logic [1:0]    tin,
    output logic          EOI,
    output logic          EOF,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [7:0]    epoch
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FETCH,
        S_PRESENT,
        S_EPOCH_END
    } state_t;

    state_t        state, state_n;
    logic [15:0]   mem [DEPTH];
    logic [15:0]   rd_data;
    logic [AW-1:0] index, index_n;
    logic [AW:0]   count, count_n;
    logic          accepted, accepted_n;
    logic          start_n, eoi_n, eof_n, busy_n, done_n, fail_n;
    logic [6:0]    x1_n, x2_n;
    logic [1:0]    tin_n;
    logic [7:0]    epoch_n, epoch_inc;
    logic          count_ok;

    // Read address follows the next index so data is ready during FETCH.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= {load_x1, load_x2, load_t};
        end
        rd_data <= mem[index_n];
    end

    assign count_ok  = (num_samples != '0) && (num_samples <= (AW+1)'(DEPTH));
    assign epoch_inc = epoch + 8'd1;

    always_comb begin
        state_n    = state;
        index_n    = index;
        count_n    = count;
        accepted_n = accepted;
        start_n    = 1'b0;
        eof_n      = 1'b0;
        eoi_n      = EOI;
        x1_n       = x1;
        x2_n       = x2;
        tin_n      = tin;
        done_n     = done;
        fail_n     = fail;
        epoch_n    = epoch;

        case (state)
            S_IDLE: begin
                if (go && count_ok) begin
                    state_n = S_START;
                    count_n = num_samples;
                    index_n = '0;
                    done_n  = 1'b0;
                    fail_n  = 1'b0;
                    epoch_n = 8'd0;
                    start_n = 1'b1;
                end
            end

            S_START: begin
                index_n = '0;
                state_n = S_FETCH;
            end

            S_FETCH: begin
                x1_n       = rd_data[15:9];
                x2_n       = rd_data[8:2];
                tin_n      = rd_data[1:0];
                eoi_n      = ({1'b0, index} == (count - (AW+1)'(1)));
                accepted_n = 1'b0;
                state_n    = S_PRESENT;
            end

            // A sample is finished only after the neuron has raised and then dropped updating.
            S_PRESENT: begin
                if (!accepted) begin
                    if (updating) begin
                        accepted_n = 1'b1;
                    end
                end else if (!updating) begin
                    accepted_n = 1'b0;
                    if (EOI) begin
                        eoi_n   = 1'b0;
                        state_n = S_EPOCH_END;
                    end else begin
                        index_n = index + AW'(1);
                        state_n = S_FETCH;
                    end
                end
            end

            S_EPOCH_END: begin
                if (!updating) begin
                    if (learned) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        epoch_n = epoch_inc;
                        if (epoch_inc == 8'(MAX_EPOCHS)) begin
                            eof_n   = 1'b1;
                            fail_n  = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            index_n = '0;
                            state_n = S_FETCH;
                        end
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            index    <= '0;
            count    <= '0;
            accepted <= 1'b0;
            start    <= 1'b0;
            x1       <= '0;
            x2       <= '0;
            tin      <= '0;
            EOI      <= 1'b0;
            EOF      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
            epoch    <= 8'd0;
        end else begin
            state    <= state_n;
            index    <= index_n;
            count    <= count_n;
            accepted <= accepted_n;
            start    <= start_n;
            x1       <= x1_n;
            x2       <= x2_n;
            tin      <= tin_n;
            EOI      <= eoi_n;
            EOF      <= eof_n;
            busy     <= busy_n;
            done     <= done_n;
            fail     <= fail_n;
            epoch    <= epoch_n;
        end
    end

endmodule
